// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain controller.
//   scan_state_e  : controller FSM states
//   SLOW_MIN_BIT  : lowest counter bit usable as the slow debug clock
//   SLOW_CNT_W    : width of the free-running slow-clock counter
package scan_pkg;

  typedef enum logic [2:0] {
    StStart,
    StLoad,
    StLatch,
    StCapture,
    StRead
  } scan_state_e;

  localparam int unsigned SLOW_MIN_BIT = 13;
  localparam int unsigned SLOW_CNT_W   = 22;

endpackage

// File: rtl/scan_chain_controller_if.sv
// Serial scan-chain bus between the controller and the design chain.
//   scan_clk          : chain shift clock
//   scan_data_out     : serial data into the chain head
//   scan_data_in      : serial data from the chain tail
//   scan_select       : high = chain flops capture design outputs
//   scan_latch_enable : high = design input latches transparent
// master = controller side, slave = chain side.
interface scan_chain_controller_if;

  logic scan_clk;
  logic scan_data_out;
  logic scan_data_in;
  logic scan_select;
  logic scan_latch_enable;

  modport master (
    output scan_clk,
    output scan_data_out,
    output scan_select,
    output scan_latch_enable,
    input  scan_data_in
  );

  modport slave (
    input  scan_clk,
    input  scan_data_out,
    input  scan_select,
    input  scan_latch_enable,
    output scan_data_in
  );

endinterface

// File: rtl/scan_slow_clk.sv
// Slow debug clock generator: a free-running SLOW_CNT_W-bit counter whose bit
// (SLOW_MIN_BIT + select) is brought out, registered, as slow_clk.
//   clk, reset_n : system clock, async active-low reset
//   set_clk_div  : the select is loaded from div_sel on its rising edge
//   div_sel      : divider select value (clamped to the top counter bit)
//   slow_clk     : divided clock
module scan_slow_clk
  import scan_pkg::*;
#(
  parameter int unsigned NUM_IOS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               set_clk_div,
  input  logic [NUM_IOS-1:0] div_sel,
  output logic               slow_clk
);

  localparam int unsigned IdxW   = $clog2(SLOW_CNT_W);
  localparam int unsigned MaxSel = SLOW_CNT_W - 1 - SLOW_MIN_BIT;

  logic [SLOW_CNT_W-1:0] cnt_q;
  logic [NUM_IOS-1:0]    sel_q;
  logic                  set_q;
  logic                  slow_q;
  logic [IdxW-1:0]       bit_idx;

  always_comb begin
    bit_idx = IdxW'(SLOW_CNT_W - 1);
    if (int'(sel_q) <= int'(MaxSel)) begin
      bit_idx = IdxW'(int'(sel_q) + int'(SLOW_MIN_BIT));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      set_q  <= 1'b0;
      slow_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      set_q  <= set_clk_div;
      slow_q <= cnt_q[bit_idx];
      if (set_clk_div && !set_q) begin
        sel_q <= div_sel;
      end
    end
  end

  assign slow_clk = slow_q;

endmodule

// File: rtl/scan_chain_controller.sv
// Scan-chain controller. Shifts the user inputs into the selected design on a
// shared chain of NUM_DESIGNS x NUM_IOS flops, latches them, captures every
// design's outputs, shifts them back and presents the selected design's outputs.
// Each scan bit takes 2*SCAN_DIV clk cycles: scan_clk low SCAN_DIV, high SCAN_DIV.
// Optional feature macro: SCAN_SLOW_CLK_EN (slow debug clock via scan_slow_clk).
// Ports:
//   clk, reset_n   : system clock, async active-low reset
//   enable         : 1 = refresh continuously, 0 = park in START after this refresh
//   active_select  : design connected to inputs/outputs (sampled in START)
//   inputs         : values driven into the selected design (sampled in START)
//   set_clk_div    : slow clock select/load (SCAN_SLOW_CLK_EN only)
//   outputs        : last captured outputs of the selected design
//   ready          : high while in START
//   slow_clk       : divided debug clock (0 without SCAN_SLOW_CLK_EN)
//   chain          : scan-chain bus, master side
module scan_chain_controller
  import scan_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 8,
  parameter int unsigned NUM_IOS     = 8,
  parameter int unsigned SCAN_DIV    = 1,
  parameter int unsigned SEL_W       = $clog2(NUM_DESIGNS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [SEL_W-1:0]       active_select,
  input  logic [NUM_IOS-1:0]     inputs,
  input  logic                   set_clk_div,
  output logic [NUM_IOS-1:0]     outputs,
  output logic                   ready,
  output logic                   slow_clk,
  scan_chain_controller_if.master chain
);

  localparam int unsigned IO_W = $clog2(NUM_IOS);
  localparam int unsigned PH_W = $clog2(2 * SCAN_DIV);

  localparam logic [PH_W-1:0]  PhLast    = PH_W'(2 * SCAN_DIV - 1);
  localparam logic [PH_W-1:0]  PhHigh    = PH_W'(SCAN_DIV);
  localparam logic [PH_W-1:0]  PhPreRise = PH_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] DLast     = SEL_W'(NUM_DESIGNS - 1);
  localparam logic [IO_W-1:0]  ILast     = IO_W'(NUM_IOS - 1);
  localparam logic [SEL_W:0]   DHit      = (SEL_W + 1)'(NUM_DESIGNS - 1);

  scan_state_e        state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [SEL_W-1:0]   d_q, d_d;
  logic [IO_W-1:0]    i_q, i_d;
  logic [NUM_IOS-1:0] inputs_r_q, inputs_r_d;
  logic [SEL_W-1:0]   sel_r_q, sel_r_d;
  logic [NUM_IOS-1:0] out_buf_q, out_buf_d;
  logic [NUM_IOS-1:0] outputs_q, outputs_d;
  logic               ready_q, ready_d;
  logic               sck_q, sck_d;
  logic               sdo_q, sdo_d;
  logic               ss_q, ss_d;
  logic               le_q, le_d;
  logic [NUM_IOS-1:0] inputs_eff;
  logic               load_hit, read_hit;
  logic               bit_end, last_pos;

`ifdef SCAN_SLOW_CLK_EN
  scan_slow_clk #(
    .NUM_IOS(NUM_IOS)
  ) u_slow_clk (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_clk_div(set_clk_div),
    .div_sel    (inputs),
    .slow_clk   (slow_clk)
  );
  assign inputs_eff = {inputs[NUM_IOS-1:1], set_clk_div ? slow_clk : inputs[0]};
`else
  logic unused_set_clk_div;
  assign unused_set_clk_div = set_clk_div;
  assign slow_clk           = 1'b0;
  assign inputs_eff         = inputs;
`endif

  // FSM and position counters.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    d_d      = d_q;
    i_d      = i_q;
    bit_end  = (ph_q == PhLast);
    last_pos = (d_q == DLast) && (i_q == ILast);
    unique case (state_q)
      StStart: begin
        ph_d = '0;
        d_d  = '0;
        i_d  = '0;
        if (enable) state_d = StLoad;
      end
      StLoad, StRead: begin
        ph_d = ph_q + 1'b1;
        if (bit_end) begin
          ph_d = '0;
          if (i_q == ILast) begin
            i_d = '0;
            d_d = d_q + 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
          if (last_pos) begin
            d_d     = '0;
            state_d = (state_q == StLoad) ? StLatch : StStart;
          end
        end
      end
      StLatch: begin
        ph_d = ph_q + 1'b1;
        if (bit_end) begin
          ph_d    = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        ph_d = ph_q + 1'b1;
        if (bit_end) begin
          ph_d    = '0;
          state_d = StRead;
        end
      end
      default: state_d = StStart;
    endcase
  end

  // Datapath and registered outputs, all derived from next-state values so the
  // pins change exactly on the clock edge that enters the new phase.
  always_comb begin
    inputs_r_d = inputs_r_q;
    sel_r_d    = sel_r_q;
    if (state_q == StStart) begin
      inputs_r_d = inputs_eff;
      sel_r_d    = active_select;
    end

    // Chain position d carries design NUM_DESIGNS-1-d; widened add avoids underflow
    // when sel is out of range.
    load_hit = (({1'b0, d_d} + {1'b0, sel_r_d}) == DHit);
    read_hit = (({1'b0, d_q} + {1'b0, sel_r_q}) == DHit);

    sdo_d = 1'b0;
    if ((state_d == StLoad) && load_hit) begin
      sdo_d = inputs_r_d[ILast - i_d];
    end

    out_buf_d = out_buf_q;
    if ((state_q == StRead) && (ph_q == PhPreRise) && read_hit) begin
      out_buf_d[ILast - i_q] = chain.scan_data_in;
    end

    outputs_d = (state_d == StStart) ? out_buf_q : outputs_q;
    ready_d   = (state_d == StStart);
    sck_d     = (state_d inside {StLoad, StCapture, StRead}) && (ph_d >= PhHigh);
    ss_d      = (state_d == StCapture);
    le_d      = (state_d == StLatch);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StStart;
      ph_q       <= '0;
      d_q        <= '0;
      i_q        <= '0;
      inputs_r_q <= '0;
      sel_r_q    <= '0;
      out_buf_q  <= '0;
      outputs_q  <= '0;
      ready_q    <= 1'b0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      ss_q       <= 1'b0;
      le_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      d_q        <= d_d;
      i_q        <= i_d;
      inputs_r_q <= inputs_r_d;
      sel_r_q    <= sel_r_d;
      out_buf_q  <= out_buf_d;
      outputs_q  <= outputs_d;
      ready_q    <= ready_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      ss_q       <= ss_d;
      le_q       <= le_d;
    end
  end

  assign outputs                 = outputs_q;
  assign ready                   = ready_q;
  assign chain.scan_clk          = sck_q;
  assign chain.scan_data_out     = sdo_q;
  assign chain.scan_select       = ss_q;
  assign chain.scan_latch_enable = le_q;

endmodule
